ram_tp_bytemask_init: RTL and testbench

RAM_TP_BYTEMASK_INIT -- requirements
Module: ram_tp_bytemask_init

---
 rtl/ram_pkg.sv | 22 ++
 rtl/ram_rd_pipe.sv | 52 +++++
 rtl/ram_tp_bytemask_init.sv | 148 ++++++++++++++
 tb/tb_ram_tp_bytemask_init.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_pkg
// Description : Shared definitions for the byte-masked two-port RAM with a
//               clear sequence. Provides the clear FSM state encoding and the
//               read-latency legality check.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    // Clear FSM state encoding
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_CLEAR = 1'b1;

    // Only one or two register stages are supported on the read path
    function automatic bit rd_latency_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ram_rd_pipe
// Description : Read-result latency pipeline. Carries a valid flag and a data
//               word through READ_LATENCY register stages. Each data stage
//               loads only when its input stage is valid, so the output word
//               holds its last value while o_valid is low.
// Ports       : clock, reset_n    - clock, async active-low reset
//               i_valid, i_data   - read result entering the pipe
//               o_valid, o_data   - read result after READ_LATENCY cycles
// Revision    : 1.0 - initial release
// ============================================================================
module ram_rd_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [READ_LATENCY-1:0] r_vld;
    logic [DATA_WIDTH-1:0]   r_dat [READ_LATENCY];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_dat[0] <= i_data;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end

    assign o_valid = r_vld[READ_LATENCY-1];
    assign o_data  = r_dat[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/ram_tp_bytemask_init.sv
`default_nettype none
// ============================================================================
// Module      : ram_tp_bytemask_init
// Description : Two-port (one write, one read) RAM with per-byte write
//               enables, selectable write-first/read-first collision handling,
//               1- or 2-cycle read latency and a hardware clear sequence that
//               fills every entry with INIT_VALUE after reset or on request.
// Ports       : clock, reset_n              - clock, async active-low reset
//               init_req                    - one-cycle request to re-clear
//               busy                        - clear sequence in progress
//               wr_en, wr_bwen, wr_addr,
//               wr_data                     - write port (byte enables)
//               rd_en, rd_addr              - read request
//               rd_data, rd_valid           - read result
// Revision    : 1.0 - initial release
// ============================================================================
module ram_tp_bytemask_init
    import ram_pkg::*;
#(
    parameter int                  DATA_WIDTH   = 32,
    parameter int                  DEPTH        = 16,
    parameter int                  READ_LATENCY = 1,
    parameter int                  BYPASS       = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            init_req,
    output logic                            busy,
    input  logic                            wr_en,
    input  logic [DATA_WIDTH/8-1:0]         wr_bwen,
    input  logic [$clog2(DEPTH)-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic                            rd_en,
    input  logic [$clog2(DEPTH)-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            rd_valid
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int BWEN_WIDTH = DATA_WIDTH / 8;

    // One extra bit so DEPTH itself is representable for range checks
    localparam logic [ADDR_WIDTH:0]   c_DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_LAST    = ADDR_WIDTH'(DEPTH - 1);

    // Elaboration-time parameter checks
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("ram_tp_bytemask_init: DATA_WIDTH must be a multiple of 8");
    end
    if (!rd_latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("ram_tp_bytemask_init: READ_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;

    logic                  w_busy;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_rd_inrange;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_busy  = (r_state == c_ST_CLEAR);
    assign busy    = w_busy;

    // User accesses are locked out for the whole clear sequence
    assign w_wr_ok      = wr_en && !w_busy && ({1'b0, wr_addr} < c_DEPTH_W);
    assign w_rd_ok      = rd_en && !w_busy;
    assign w_rd_inrange = ({1'b0, rd_addr} < c_DEPTH_W);
    assign w_hit        = w_wr_ok && (wr_addr == rd_addr);

    assign w_old = r_mem[wr_addr];

    for (genvar b = 0; b < BWEN_WIDTH; b++) begin : g_byte
        assign w_merged[8*b +: 8] = wr_bwen[b] ? wr_data[8*b +: 8] : w_old[8*b +: 8];
    end

    // Out-of-range reads return zero; a colliding write is forwarded only
    // in write-first mode, otherwise the array still holds the old word.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_inrange) begin
            if ((BYPASS != 0) && w_hit) begin
                w_rd_word = w_merged;
            end else begin
                w_rd_word = r_mem[rd_addr];
            end
        end
    end

    // Storage has no reset; the clear sequence owns the port while busy
    always_ff @(posedge clock) begin
        if (w_busy) begin
            r_mem[r_cnt] <= INIT_VALUE;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= w_merged;
        end
    end

    // Clear FSM: counter runs 0..DEPTH-1 and is compared against DEPTH-1
    // only, so non-power-of-two depths never touch unused addresses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_CLEAR: begin
                    if (r_cnt == c_LAST) begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_IDLE: begin
                    if (init_req) begin
                        r_state <= c_ST_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    ram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .i_valid (w_rd_ok),
        .i_data  (w_rd_word),
        .o_valid (rd_valid),
        .o_data  (rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_ram_tp_bytemask_init.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_tp_bytemask_init
// Description : Scoreboard bench for ram_tp_bytemask_init. Instance A:
//               DEPTH=16, INIT=A5A5A5A5, write-first, latency 1. Instance B:
//               DEPTH=10, INIT=0, read-first, latency 2. Both share stimulus;
//               the idle instance is held in reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_tp_bytemask_init;

    logic        clock = 1'b0;
    logic        rst_a_n, rst_b_n;
    logic        init_req, wr_en, rd_en;
    logic [3:0]  wr_bwen, wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic        busy_a, busy_b, rd_valid_a, rd_valid_b;
    logic [31:0] rd_data_a, rd_data_b;

    always #5 clock = ~clock;

    ram_tp_bytemask_init #(
        .DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(1), .BYPASS(1),
        .INIT_VALUE(32'hA5A5A5A5)
    ) u_dut_a (
        .clock(clock), .reset_n(rst_a_n), .init_req(init_req), .busy(busy_a),
        .wr_en(wr_en), .wr_bwen(wr_bwen), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    ram_tp_bytemask_init #(
        .DATA_WIDTH(32), .DEPTH(10), .READ_LATENCY(2), .BYPASS(0),
        .INIT_VALUE(32'h0)
    ) u_dut_b (
        .clock(clock), .reset_n(rst_b_n), .init_req(init_req), .busy(busy_b),
        .wr_en(wr_en), .wr_bwen(wr_bwen), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   vcnt_b = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation whenever a DUT presents a read result
    always @(negedge clock) begin
        exp_t e;
        if (rd_valid_a === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                check("a_rd_data", rd_data_a, e.data);
                check("a_rd_cycle", 32'(cyc), 32'(e.due));
            end
        end
        if (rd_valid_b === 1'b1) begin
            vcnt_b = vcnt_b + 1;
            if (qb.size() == 0) begin
                check("b_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                check("b_rd_data", rd_data_b, e.data);
                check("b_rd_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic push(input int inst, input logic [31:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + ((inst != 0) ? 2 : 1);
        if (inst != 0) qb.push_back(e);
        else           qa.push_back(e);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_bwen = be;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic rd(input int inst, input logic [3:0] a, input logic [31:0] exp);
        rd_en = 1'b1; rd_addr = a;
        push(inst, exp);
        @(negedge clock);
        rd_en = 1'b0;
    endtask

    task automatic wr_rd(input int inst, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [31:0] exp);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_bwen = be;
        rd_en = 1'b1; rd_addr = a;
        push(inst, exp);
        @(negedge clock);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (((qa.size() + qb.size()) != 0) && (n < 20)) begin
            @(negedge clock);
            n++;
        end
        check("drain_pending", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    // Counts cycles with busy high, optionally pulsing init_req mid-clear
    task automatic count_busy(input int inst, input int pulse_at, output int n);
        n = 0;
        while (((inst != 0) ? busy_b : busy_a) && (n < 100)) begin
            init_req = (n == pulse_at);
            @(negedge clock);
            n++;
        end
        init_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        int          vsnap;
        logic [31:0] exp_b;

        init_req = 0; wr_en = 0; rd_en = 0;
        wr_bwen = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
        rst_a_n = 0; rst_b_n = 0;
        repeat (3) @(negedge clock);

        // ---------------- Instance A ----------------
        check("a_reset_busy",  32'(busy_a), 32'd1);
        check("a_reset_valid", 32'(rd_valid_a), 32'd0);
        check("a_reset_data",  rd_data_a, 32'd0);
        rst_a_n = 1;
        count_busy(0, -1, n);
        check("a_clear_cycles", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) rd(0, 4'(i), 32'hA5A5A5A5);

        wr(4'd3, 32'h11223344, 4'b1111);
        wr(4'd3, 32'hAABBCCDD, 4'b0101);
        rd(0, 4'd3, 32'h11BB33DD);
        wr(4'd3, 32'hFFFFFFFF, 4'b0000);
        rd(0, 4'd3, 32'h11BB33DD);

        wr(4'd5, 32'h00000000, 4'b1111);
        wr_rd(0, 4'd5, 32'hFFFFFFFF, 4'b1111, 32'hFFFFFFFF);
        wr_rd(0, 4'd5, 32'h00000000, 4'b0011, 32'hFFFF0000);
        rd(0, 4'd5, 32'hFFFF0000);
        drain();
        rst_a_n = 0;
        @(negedge clock);

        // ---------------- Instance B ----------------
        check("b_reset_busy",  32'(busy_b), 32'd1);
        check("b_reset_valid", 32'(rd_valid_b), 32'd0);
        rst_b_n = 1;
        count_busy(1, 3, n);
        check("b_clear_cycles_init_ignored", 32'(n), 32'd10);

        wr_rd(1, 4'd5, 32'hFFFFFFFF, 4'b1111, 32'h00000000);
        rd(1, 4'd5, 32'hFFFFFFFF);

        for (int i = 0; i < 4; i++) wr(4'(i), 32'h10000000 + i, 4'b1111);
        for (int i = 0; i < 4; i++) rd(1, 4'(i), 32'h10000000 + i);
        drain();
        repeat (3) @(negedge clock);
        check("b_hold_data",  rd_data_b, 32'h10000003);
        check("b_hold_valid", 32'(rd_valid_b), 32'd0);

        wr(4'd12, 32'hDEADBEEF, 4'b1111);
        rd(1, 4'd12, 32'h00000000);
        for (int i = 0; i < 10; i++) begin
            if (i < 4)       exp_b = 32'h10000000 + i;
            else if (i == 5) exp_b = 32'hFFFFFFFF;
            else             exp_b = 32'h00000000;
            rd(1, 4'(i), exp_b);
        end

        // Read accepted together with init_req completes with pre-clear data
        rd_en = 1; rd_addr = 4'd3; init_req = 1;
        push(1, 32'h10000003);
        @(negedge clock);
        rd_en = 0; init_req = 0;
        check("b_init_busy", 32'(busy_b), 32'd1);
        repeat (4) @(negedge clock);
        check("b_pre_reset_data", rd_data_b, 32'h10000003);
        check("b_pre_reset_pending", 32'(qb.size()), 32'd0);

        // Reset in the 5th clear cycle, mid-cycle
        #2 rst_b_n = 0;
        #1;
        check("b_midclear_rst_data",  rd_data_b, 32'd0);
        check("b_midclear_rst_valid", 32'(rd_valid_b), 32'd0);
        check("b_midclear_rst_busy",  32'(busy_b), 32'd1);

        // Accesses driven throughout the clear must have no effect
        wr_en = 1; wr_addr = 4'd0; wr_data = 32'hDEADBEEF; wr_bwen = 4'b1111;
        rd_en = 1; rd_addr = 4'd1;
        vsnap = vcnt_b;
        @(negedge clock);
        rst_b_n = 1;
        count_busy(1, -1, n);
        wr_en = 0; rd_en = 0;
        check("b_restart_clear_cycles", 32'(n), 32'd10);
        check("b_busy_no_valid", 32'(vcnt_b), 32'(vsnap));

        for (int i = 0; i < 6; i++) rd(1, 4'(i), 32'h00000000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
